// File: rtl/delay_cal_pkg.sv
// Shared definitions for the delay eye calibrator.
//   TAP_WIDTH / LEN_WIDTH : tap index width and run-length width (a run of
//                           512 taps must fit, hence one extra bit).
//   cal_state_t           : calibrator FSM states.
//   eye_result_t          : {found, lo, hi, centre} of the best passing run.
//   eye_from_run()        : turns a run {start, len} into an eye_result_t.
package delay_cal_pkg;

  localparam int TAP_WIDTH = 9;
  localparam int LEN_WIDTH = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_SAMPLE,
    ST_EVAL,
    ST_CENTRE,
    ST_DONE
  } cal_state_t;

  typedef struct packed {
    logic                 found;
    logic [TAP_WIDTH-1:0] lo;
    logic [TAP_WIDTH-1:0] hi;
    logic [TAP_WIDTH-1:0] centre;
  } eye_result_t;

  // An empty run (len == 0) yields all zeros, so "no eye" loads tap 0.
  function automatic eye_result_t eye_from_run(input logic [TAP_WIDTH-1:0] start,
                                               input logic [LEN_WIDTH-1:0] len);
    eye_result_t          r;
    logic [LEN_WIDTH-1:0] last_off;
    r        = '0;
    last_off = len - LEN_WIDTH'(1);
    if (len != '0) begin
      r.found  = 1'b1;
      r.lo     = start;
      // last_off <= 511 here, so the low 9 bits hold it exactly.
      r.hi     = start + last_off[TAP_WIDTH-1:0];
      // (len-1)>>1 : centre rounded down towards the low edge.
      r.centre = start + last_off[TAP_WIDTH:1];
    end
    return r;
  endfunction

endpackage

// File: rtl/delay_cal_run_tracker.sv
// Tracks the longest contiguous run of passing taps during a sweep.
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : zero the current and best runs (start of calibration)
//   evaluate     : one-cycle strobe, fold the verdict for 'tap' into the runs
//   pass         : verdict for 'tap'
//   tap          : tap being evaluated
//   result       : eye derived from the best run *including* this cycle's
//                  evaluate, so the caller can register it in the same edge
//                  that commits the final tap.
module delay_cal_run_tracker
  import delay_cal_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 evaluate,
  input  logic                 pass,
  input  logic [TAP_WIDTH-1:0] tap,
  output eye_result_t          result
);

  logic [TAP_WIDTH-1:0] cur_start, cur_start_nxt;
  logic [TAP_WIDTH-1:0] best_start, best_start_nxt;
  logic [LEN_WIDTH-1:0] cur_len, cur_len_nxt;
  logic [LEN_WIDTH-1:0] best_len, best_len_nxt;

  always_comb begin
    cur_start_nxt  = cur_start;
    cur_len_nxt    = cur_len;
    best_start_nxt = best_start;
    best_len_nxt   = best_len;
    if (clear) begin
      cur_start_nxt  = '0;
      cur_len_nxt    = '0;
      best_start_nxt = '0;
      best_len_nxt   = '0;
    end else if (evaluate) begin
      if (pass) begin
        if (cur_len == '0) begin
          cur_start_nxt = tap;
        end
        cur_len_nxt = cur_len + LEN_WIDTH'(1);
        // Strictly greater: on a tie the earlier run is kept.
        if (cur_len_nxt > best_len) begin
          best_start_nxt = cur_start_nxt;
          best_len_nxt   = cur_len_nxt;
        end
      end else begin
        cur_len_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_start  <= '0;
      cur_len    <= '0;
      best_start <= '0;
      best_len   <= '0;
    end else begin
      cur_start  <= cur_start_nxt;
      cur_len    <= cur_len_nxt;
      best_start <= best_start_nxt;
      best_len   <= best_len_nxt;
    end
  end

  assign result = eye_from_run(best_start_nxt, best_len_nxt);

endmodule

// File: rtl/delay_eye_calibrator.sv
// Sweeps an IDELAY/ODELAY tap from 0 to MAX_TAP, qualifies each tap with
// SAMPLE_CYCLES cycles of sample_ok (after SETTLE_CYCLES of settling), and
// loads the centre of the longest passing run. When idle, a manual load
// request is passed through to the delay pair.
//   clk, reset_n          : clock, asynchronous active-low reset
//   start, abort          : begin calibration (IDLE only) / return to IDLE
//   sample_ok             : per-cycle pattern match, synchronous to clk
//   manual_load/_value    : one-cycle manual tap load request (IDLE only)
//   delay__load/_value    : load strobe and tap value to the delay pair
//   busy, done            : not-IDLE flag, one-cycle completion pulse
//   eye_found/lo/hi/centre: best-run result, held until the next start
//   fsm_state             : current FSM state, for observation
// Strobe semantics: delay__load is a single-cycle strobe with no back-pressure;
// delay__value is meaningful only in a cycle where delay__load is high.
// All outputs come straight from flops; next values are decoded from the
// next state, so each output lines up with the state it belongs to.
module delay_eye_calibrator
  import delay_cal_pkg::*;
#(
  parameter int MAX_TAP       = 511,
  parameter int SETTLE_CYCLES = 8,
  parameter int SAMPLE_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 sample_ok,
  input  logic                 manual_load,
  input  logic [TAP_WIDTH-1:0] manual_value,
  output logic                 delay__load,
  output logic [TAP_WIDTH-1:0] delay__value,
  output logic                 busy,
  output logic                 done,
  output logic                 eye_found,
  output logic [TAP_WIDTH-1:0] eye_lo,
  output logic [TAP_WIDTH-1:0] eye_hi,
  output logic [TAP_WIDTH-1:0] eye_centre,
  output cal_state_t           fsm_state
);

  localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]     SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]     SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);
  localparam logic [TAP_WIDTH-1:0] TAP_LAST    = TAP_WIDTH'(MAX_TAP);

  cal_state_t           state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [TAP_WIDTH-1:0] tap, tap_nxt;
  logic                 pass_acc, pass_nxt;
  logic                 load_nxt;
  logic [TAP_WIDTH-1:0] value_nxt;
  logic                 done_nxt;
  eye_result_t          eye_q, eye_nxt;
  logic                 tr_clear, tr_eval;
  eye_result_t          tr_result;

  delay_cal_run_tracker u_tracker (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (tr_clear),
    .evaluate (tr_eval),
    .pass     (pass_acc),
    .tap      (tap),
    .result   (tr_result)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    tap_nxt   = tap;
    pass_nxt  = pass_acc;
    load_nxt  = 1'b0;
    value_nxt = delay__value;
    done_nxt  = 1'b0;
    eye_nxt   = eye_q;
    tr_clear  = 1'b0;
    tr_eval   = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (start) begin
          // start wins over a simultaneous manual_load.
          state_nxt = ST_LOAD;
          tap_nxt   = '0;
          tr_clear  = 1'b1;
          eye_nxt   = '0;
          load_nxt  = 1'b1;
          value_nxt = '0;
        end else if (manual_load) begin
          load_nxt  = 1'b1;
          value_nxt = manual_value;
        end
      end
      ST_LOAD: begin
        state_nxt = ST_SETTLE;
        cnt_nxt   = '0;
      end
      ST_SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          state_nxt = ST_SAMPLE;
          cnt_nxt   = '0;
          pass_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_SAMPLE: begin
        pass_nxt = pass_acc & sample_ok;
        if (cnt == SAMPLE_LAST) begin
          state_nxt = ST_EVAL;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_EVAL: begin
        tr_eval = 1'b1;
        if (tap == TAP_LAST) begin
          // tr_result already reflects this final tap, so the centre load
          // appears in the CENTRE cycle itself.
          state_nxt = ST_CENTRE;
          eye_nxt   = tr_result;
          load_nxt  = 1'b1;
          value_nxt = tr_result.centre;
        end else begin
          state_nxt = ST_LOAD;
          tap_nxt   = tap + TAP_WIDTH'(1);
          load_nxt  = 1'b1;
          value_nxt = tap + TAP_WIDTH'(1);
        end
      end
      ST_CENTRE: begin
        state_nxt = ST_DONE;
        done_nxt  = 1'b1;
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // abort overrides every transition outside IDLE: no final load, no done.
    if (state != ST_IDLE && abort) begin
      state_nxt     = ST_IDLE;
      load_nxt      = 1'b0;
      value_nxt     = delay__value;
      done_nxt      = 1'b0;
      tr_eval       = 1'b0;
      eye_nxt       = eye_q;
      eye_nxt.found = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      tap          <= '0;
      pass_acc     <= 1'b0;
      delay__load  <= 1'b0;
      delay__value <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      eye_q        <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      tap          <= tap_nxt;
      pass_acc     <= pass_nxt;
      delay__load  <= load_nxt;
      delay__value <= value_nxt;
      busy         <= (state_nxt != ST_IDLE);
      done         <= done_nxt;
      eye_q        <= eye_nxt;
    end
  end

  assign eye_found  = eye_q.found;
  assign eye_lo     = eye_q.lo;
  assign eye_hi     = eye_q.hi;
  assign eye_centre = eye_q.centre;
  assign fsm_state  = state;

endmodule

// File: tb/tb_delay_eye_calibrator.sv
// Bench for delay_eye_calibrator with MAX_TAP=31, SETTLE=2, SAMPLE=4 (P=8).
module tb_delay_eye_calibrator;
  import delay_cal_pkg::*;

  localparam int MAX_TAP    = 31;
  localparam int SETTLE     = 2;
  localparam int SAMPLE     = 4;
  localparam int P          = 2 + SETTLE + SAMPLE;
  localparam int NTAP       = MAX_TAP + 1;
  localparam int CENTRE_CYC = 1 + NTAP * P;
  localparam int LAST       = CENTRE_CYC + 4;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       sample_ok = 1'b0;
  logic       manual_load = 1'b0;
  logic [8:0] manual_value = '0;
  logic       delay__load;
  logic [8:0] delay__value;
  logic       busy, done, eye_found;
  logic [8:0] eye_lo, eye_hi, eye_centre;
  cal_state_t fsm_state;

  always #5 clk = ~clk;

  delay_eye_calibrator #(
    .MAX_TAP       (MAX_TAP),
    .SETTLE_CYCLES (SETTLE),
    .SAMPLE_CYCLES (SAMPLE)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .abort        (abort),
    .sample_ok    (sample_ok),
    .manual_load  (manual_load),
    .manual_value (manual_value),
    .delay__load  (delay__load),
    .delay__value (delay__value),
    .busy         (busy),
    .done         (done),
    .eye_found    (eye_found),
    .eye_lo       (eye_lo),
    .eye_hi       (eye_hi),
    .eye_centre   (eye_centre),
    .fsm_state    (fsm_state)
  );

  // ---------------- scoreboard state ----------------
  int         n_checks = 0;
  int         n_err = 0;
  logic [8:0] exp_q[$];
  int         exp_cyc_q[$];
  logic       sok_pat[0:LAST];
  logic       tap_pass[0:MAX_TAP];
  logic       m_found;
  int         m_lo, m_hi, m_centre;

  typedef struct {
    logic [31:0] mask;
    int          glitch_tap;
    int          abort_cyc;
    int          restart_cyc;
    logic        manual_at_start;
    logic        exp_found;
    int          exp_lo;
    int          exp_hi;
    int          exp_centre;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_load"},    delay__load, 0);
    chk({tag, "_value"},   delay__value, 0);
    chk({tag, "_busy"},    busy, 0);
    chk({tag, "_done"},    done, 0);
    chk({tag, "_found"},   eye_found, 0);
    chk({tag, "_lo"},      eye_lo, 0);
    chk({tag, "_hi"},      eye_hi, 0);
    chk({tag, "_centre"},  eye_centre, 0);
    chk({tag, "_state"},   int'(fsm_state), int'(ST_IDLE));
  endtask

  // Per-cycle sample_ok, indexed by cycle relative to the start cycle.
  // Outside the sample windows the values are random: they must be ignored.
  task automatic build_pattern(input logic [31:0] mask, input int glitch_tap, input logic noisy);
    int k;
    for (int c = 0; c <= LAST; c++) sok_pat[c] = 1'($urandom_range(0, 1));
    for (int t = 0; t < NTAP; t++) begin
      for (int ph = SETTLE + 1; ph <= SETTLE + SAMPLE; ph++) begin
        k = 1 + t * P + ph;
        sok_pat[k] = mask[t];
        if (t == glitch_tap && ph == SETTLE + 2) sok_pat[k] = 1'b0;
        if (noisy && $urandom_range(0, 15) == 0) sok_pat[k] = 1'b0;
      end
    end
  endtask

  // Reference: a tap passes if every cycle of its window was high; the eye is
  // the first longest run of passing taps.
  task automatic model_eye();
    int best_s, best_l, l;
    for (int t = 0; t < NTAP; t++) begin
      tap_pass[t] = 1'b1;
      for (int ph = SETTLE + 1; ph <= SETTLE + SAMPLE; ph++)
        tap_pass[t] = tap_pass[t] & sok_pat[1 + t * P + ph];
    end
    best_s = 0;
    best_l = 0;
    for (int s = 0; s < NTAP; s++) begin
      l = 0;
      for (int j = s; j < NTAP; j++) begin
        if (!tap_pass[j]) break;
        l++;
      end
      if (l > best_l) begin
        best_l = l;
        best_s = s;
      end
    end
    m_found  = (best_l > 0);
    m_lo     = m_found ? best_s : 0;
    m_hi     = m_found ? best_s + best_l - 1 : 0;
    m_centre = m_found ? best_s + (best_l - 1) / 2 : 0;
  endtask

  // One calibration run; entered just after a rising edge with the DUT idle.
  task automatic run_sweep(input string tag, input int abort_cyc, input int restart_cyc,
                           input logic manual_at_start, input logic exp_found,
                           input int exp_lo, input int exp_hi, input int exp_centre);
    int         done_seen;
    int         last_busy;
    int         exp_done;
    int         ec;
    logic [8:0] e;
    done_seen = 0;
    exp_q.delete();
    exp_cyc_q.delete();
    for (int t = 0; t < NTAP; t++) begin
      if (abort_cyc < 0 || 1 + t * P < abort_cyc) begin
        exp_q.push_back(9'(t));
        exp_cyc_q.push_back(1 + t * P);
      end
    end
    if (abort_cyc < 0) begin
      exp_q.push_back(9'(exp_centre));
      exp_cyc_q.push_back(CENTRE_CYC);
    end
    last_busy = (abort_cyc < 0) ? CENTRE_CYC + 1 : abort_cyc;
    exp_done  = (abort_cyc < 0) ? CENTRE_CYC + 1 : -1;

    for (int k = 0; k <= LAST; k++) begin
      start     = (k == 0) || (k == restart_cyc);
      abort     = (k == abort_cyc);
      sample_ok = sok_pat[k];
      if (k == 0) begin
        manual_load  = manual_at_start;
        manual_value = 9'h1FF;
      end else if (k <= last_busy) begin
        manual_load  = 1'($urandom_range(0, 1));
        manual_value = 9'($urandom_range(0, 511));
      end else begin
        manual_load = 1'b0;
      end
      @(negedge clk);
      if (delay__load) begin
        if (exp_q.size() == 0) begin
          chk({tag, "_extra_strobe_cycle"}, k, -1);
        end else begin
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          chk({tag, "_strobe_value"}, delay__value, e);
          chk({tag, "_strobe_cycle"}, k, ec);
        end
      end
      if (done) begin
        done_seen++;
        chk({tag, "_done_cycle"}, k, exp_done);
      end
      if (k == 0) chk({tag, "_busy_c0"}, busy, 0);
      if (k == 1) begin
        chk({tag, "_busy_c1"}, busy, 1);
        chk({tag, "_found_cleared"}, eye_found, 0);
        chk({tag, "_centre_cleared"}, eye_centre, 0);
      end
      if (k == last_busy) chk({tag, "_busy_last"}, busy, 1);
      if (k == last_busy + 1) begin
        chk({tag, "_busy_fall"}, busy, 0);
        chk({tag, "_idle"}, int'(fsm_state), int'(ST_IDLE));
      end
      @(posedge clk);
      #1;
    end
    start       = 1'b0;
    abort       = 1'b0;
    manual_load = 1'b0;
    chk({tag, "_missing_strobes"}, exp_q.size(), 0);
    chk({tag, "_done_count"}, done_seen, (abort_cyc < 0) ? 1 : 0);
    chk({tag, "_eye_found"}, eye_found, exp_found);
    if (abort_cyc < 0) begin
      chk({tag, "_eye_lo"}, eye_lo, exp_lo);
      chk({tag, "_eye_hi"}, eye_hi, exp_hi);
      chk({tag, "_eye_centre"}, eye_centre, exp_centre);
    end
  endtask

  initial begin
    int strobes;
    int busy_hi;
    logic [31:0] rmask;

    //             mask          glitch abort restart man  found lo  hi  centre
    vecs[0] = '{32'h001FFC00, -1, -1,  -1,  1'b0, 1'b1, 10, 20, 15};
    vecs[1] = '{32'h0000F078, -1, -1,  -1,  1'b0, 1'b1,  3,  6,  4};
    vecs[2] = '{32'h00000000, -1, -1,  -1,  1'b0, 1'b0,  0,  0,  0};
    vecs[3] = '{32'hFFFFFFFF, -1, -1,  -1,  1'b0, 1'b1,  0, 31, 15};
    vecs[4] = '{32'h001FFC00, 14, -1,  -1,  1'b0, 1'b1, 15, 20, 17};
    vecs[5] = '{32'h001FFC00, -1, -1, 100,  1'b0, 1'b1, 10, 20, 15};
    vecs[6] = '{32'h001FFC00, -1, 44,  -1,  1'b0, 1'b0,  0,  0,  0};
    vecs[7] = '{32'h001FFC00, -1, -1,  -1,  1'b1, 1'b1, 10, 20, 15};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Manual load in IDLE: strobe one cycle later with the captured value.
    manual_load  = 1'b1;
    manual_value = 9'h1A5;
    @(negedge clk);
    chk("manual_c0_load", delay__load, 0);
    @(posedge clk);
    #1;
    manual_load  = 1'b0;
    manual_value = 9'h000;
    @(negedge clk);
    chk("manual_c1_load", delay__load, 1);
    chk("manual_c1_value", delay__value, 9'h1A5);
    chk("manual_c1_busy", busy, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("manual_c2_load", delay__load, 0);
    @(posedge clk);
    #1;

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      build_pattern(vecs[i].mask, vecs[i].glitch_tap, 1'b0);
      run_sweep($sformatf("vec%0d", i), vecs[i].abort_cyc, vecs[i].restart_cyc,
                vecs[i].manual_at_start, vecs[i].exp_found,
                vecs[i].exp_lo, vecs[i].exp_hi, vecs[i].exp_centre);
    end

    // Randomized sweeps against the reference model.
    for (int i = 0; i < 6; i++) begin
      rmask = $urandom();
      if (i == 0) rmask = rmask | 32'h00FF0000;
      build_pattern(rmask, int'($urandom_range(0, 31)), 1'b1);
      model_eye();
      run_sweep($sformatf("rnd%0d", i), -1, int'($urandom_range(2, 250)),
                1'($urandom_range(0, 1)), m_found, m_lo, m_hi, m_centre);
    end

    // Reset during SETTLE of tap 3 (cycle 26).
    build_pattern(32'hFFFFFFFF, -1, 1'b0);
    for (int k = 0; k <= 26; k++) begin
      start     = (k == 0);
      sample_ok = sok_pat[k];
      if (k == 26) begin
        chk("midreset_busy_before", busy, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_all_zero("midreset");
      end else begin
        @(negedge clk);
        @(posedge clk);
        #1;
      end
    end
    start = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    strobes = 0;
    busy_hi = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      if (delay__load) strobes++;
      if (busy) busy_hi++;
    end
    chk("midreset_no_strobes", strobes, 0);
    chk("midreset_no_busy", busy_hi, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
